peripheral_dbg_soc_ctm_trace_capture: RTL and testbench
=======================================================

Name: peripheral_dbg_soc_ctm_trace_capture

Overview:
Upstream capture stage for the RISC-V core trace monitor (CTM). It samples the core's retired-instruction trace and keeps only control-transfer events: JAL, JALR and taken branches. Each kept event is timestamped and queued in a show-ahead FIFO, and lost events are accounted for with an overflow record. The CTM packetizer pops the compact event stream through a valid/ready handshake, which decouples core retirement rate from debug-ring bandwidth.

Parameters:
ADDR_WIDTH, 32, width of pc/npc fields
TS_WIDTH, 32, timestamp counter width
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2
OVF_WIDTH, 16, overflow drop counter width (<= ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  capture enable from CTM control register
trace_valid  in  1  instruction retired this cycle
trace_pc  in  ADDR_WIDTH  retired instruction PC
trace_npc  in  ADDR_WIDTH  jump/branch target
trace_jal  in  1  retired instruction is JAL
trace_jalr  in  1  retired instruction is JALR
trace_branch  in  1  retired instruction is conditional branch
trace_br_taken  in  1  branch was taken
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_kind  out  2  0=JAL 1=JALR 2=BRANCH 3=OVERFLOW
ev_ts  out  TS_WIDTH  event timestamp
ev_pc  out  ADDR_WIDTH  PC; for OVERFLOW, zero-extended drop count
ev_npc  out  ADDR_WIDTH  target; 0 for OVERFLOW
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: applied asynchronously to all state.
  - ev_valid=0; ev_kind/ev_ts/ev_pc/ev_npc=0; level=0.
  - FIFO empty; ts counter=0; ovf_pending=0; ovf_cnt=0.
- Timestamp: free-running TS_WIDTH counter, +1 every cycle, wraps to 0 with no flag. An event is stamped with the counter value of its capture cycle.
- Qualify: q = enable & trace_valid & (trace_jalr | trace_jal | (trace_branch & trace_br_taken)).
  - Kind priority when several flags are set: JALR > JAL > BRANCH.
- Pop: pop = ev_valid & ev_ready. Outputs show the FIFO head combinationally from storage.
- Full/empty: full and empty are evaluated on the start-of-cycle occupancy. A pop in a full cycle does not make room for a same-cycle push.
- Push rules, per cycle, in priority order:
  1. ovf_pending=1 and !full: push OVERFLOW record.
     - ev_pc = min(ovf_cnt + q, 2^OVF_WIDTH-1), ev_ts = current ts.
     - Clear ovf_pending and ovf_cnt.
     - A qualifying event in this cycle is dropped and is included in the record's count.
  2. ovf_pending=0, q=1, !full: push the event.
  3. q=1 and (full or ovf_pending): drop the event.
     - Set ovf_pending; ovf_cnt += 1, saturating at all-ones.
- Ordering: the first event after any loss is always an OVERFLOW record. Events are never reordered.
- Latency: an event captured in cycle N gives ev_valid=1 in cycle N+1 if the FIFO was empty. No combinational path from trace_* to ev_*.
- Simultaneous push and pop with !full: level unchanged.
- FIFO pointers: ADDR bits + 1 wrap bit; full = pointers equal except the MSB.
- enable=0: no new captures. The FIFO keeps draining, and a pending OVERFLOW record is still emitted. The timestamp keeps running.
- ev_ready asserted while ev_valid=0: no effect.

Decomposition:
- Shared package (opensocdebug): ctm_ev_kind_e enum (JAL/JALR/BRANCH/OVERFLOW), and a ctm_trace_event struct {kind, ts, pc, npc} used as the FIFO word and by the packetizer.
- One sub-module: peripheral_dbg_soc_ctm_event_fifo.
  - Parameterized show-ahead synchronous FIFO, WIDTH/DEPTH.
  - Ports: push/din/full, pop/dout/empty, level.
- The top contains qualify logic, kind priority, timestamp counter and overflow FSM.
- Overflow FSM states: IDLE (ovf_pending=0) and LOST (ovf_pending=1). IDLE->LOST on a drop; LOST->IDLE when the record is pushed.

Test Plan:
- Single JAL: reset, ev_ready=0, inject JAL pc=0x100 npc=0x200 at ts=5 -> next cycle ev_valid=1, kind=0, pc=0x100, npc=0x200, ts=5, level=1.
- Filtering: inject untaken branch, then a plain ALU op, then JAL+JALR both set -> only one entry, kind=1 (JALR).
- Overflow: ev_ready=0, 11 back-to-back JALs (DEPTH=8) -> level=8, 3 dropped. Set ev_ready=1 -> 8 JALs pop, then OVERFLOW with pc=3, followed by the next captured event.
- Full with pop: FIFO full, pop and a qualifying event in the same cycle -> event dropped, ovf_cnt=1, level=7. Next cycle OVERFLOW pushed with pc=1.
- Saturation/wrap: OVF_WIDTH=4, 20 drops -> OVERFLOW pc=15. TS_WIDTH=8, event at ts=255 then ts=0 -> stamps 255, 0.
- Enable/reset: enable=0 with events injected -> no pushes. Assert rst mid-drain -> ev_valid=0 and level=0 immediately; first post-reset event stamped with a small ts.

Source files
------------

// File: rtl/peripheral_dbg_soc_ctm_trace_capture_pkg.sv
// Shared types for the CTM trace capture stage and its packetizer.
package peripheral_dbg_soc_ctm_trace_capture_pkg;

    localparam int unsigned CTM_ADDR_WIDTH = 32;
    localparam int unsigned CTM_TS_WIDTH   = 32;

    typedef enum logic [1:0] {
        CTM_EV_JAL      = 2'd0,
        CTM_EV_JALR     = 2'd1,
        CTM_EV_BRANCH   = 2'd2,
        CTM_EV_OVERFLOW = 2'd3
    } ctm_ev_kind_e;

    // Event record at the default widths, as seen by the packetizer
    typedef struct packed {
        ctm_ev_kind_e              kind;
        logic [CTM_TS_WIDTH-1:0]   ts;
        logic [CTM_ADDR_WIDTH-1:0] pc;
        logic [CTM_ADDR_WIDTH-1:0] npc;
    } ctm_trace_event;

    typedef enum logic {
        OVF_IDLE = 1'b0,
        OVF_LOST = 1'b1
    } ctm_ovf_state_e;

    // JALR wins over JAL, which wins over a taken branch
    function automatic ctm_ev_kind_e ctm_kind_sel(input logic jal, input logic jalr);
        if (jalr) begin
            return CTM_EV_JALR;
        end else if (jal) begin
            return CTM_EV_JAL;
        end
        return CTM_EV_BRANCH;
    endfunction

endpackage

// File: rtl/peripheral_dbg_soc_ctm_event_fifo.sv
// Show-ahead synchronous FIFO; head word visible on dout while !empty.
module peripheral_dbg_soc_ctm_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status decode from start-of-cycle pointers; MSB is the wrap bit
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance and storage write
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
    end

    // Pointer and storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/peripheral_dbg_soc_ctm_trace_capture.sv
// CTM capture: filters control transfers from the retire trace, stamps them
// and queues them, replacing lost events with a single OVERFLOW record.
module peripheral_dbg_soc_ctm_trace_capture
    import peripheral_dbg_soc_ctm_trace_capture_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned OVF_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          trace_valid,
    input  logic [ADDR_WIDTH-1:0]         trace_pc,
    input  logic [ADDR_WIDTH-1:0]         trace_npc,
    input  logic                          trace_jal,
    input  logic                          trace_jalr,
    input  logic                          trace_branch,
    input  logic                          trace_br_taken,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [1:0]                    ev_kind,
    output logic [TS_WIDTH-1:0]           ev_ts,
    output logic [ADDR_WIDTH-1:0]         ev_pc,
    output logic [ADDR_WIDTH-1:0]         ev_npc,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    typedef struct packed {
        ctm_ev_kind_e          kind;
        logic [TS_WIDTH-1:0]   ts;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] npc;
    } ev_word_t;

    localparam int unsigned EW = $bits(ev_word_t);

    ctm_ovf_state_e         state_q, state_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [OVF_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [OVF_WIDTH-1:0]   ovf_sat;
    logic [OVF_WIDTH-1:0]   ovf_rec;
    logic                   qual;
    ctm_ev_kind_e           kind_sel;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    ev_word_t               fifo_din;
    ev_word_t               fifo_dout;

    // Qualify control transfers and pick the reported kind
    always_comb begin
        qual     = enable & trace_valid &
                   (trace_jalr | trace_jal | (trace_branch & trace_br_taken));
        kind_sel = ctm_kind_sel(trace_jal, trace_jalr);
        ovf_sat  = (&ovf_cnt_q) ? ovf_cnt_q : ovf_cnt_q + OVF_WIDTH'(1);
        ovf_rec  = qual ? ovf_sat : ovf_cnt_q;
        ts_d     = ts_q + TS_WIDTH'(1);
    end

    // State, timestamp and drop counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OVF_IDLE;
            ts_q      <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Overflow FSM next state: enter LOST on any drop, leave once the record is queued
    always_comb begin
        state_d = state_q;
        if (state_q == OVF_LOST && !fifo_full) begin
            state_d = OVF_IDLE;
        end else if (qual && (fifo_full || state_q == OVF_LOST)) begin
            state_d = OVF_LOST;
        end
    end

    // Push decision: pending OVERFLOW record first, then the live event, else drop
    always_comb begin
        fifo_push = 1'b0;
        fifo_din  = '0;
        ovf_cnt_d = ovf_cnt_q;
        if (state_q == OVF_LOST && !fifo_full) begin
            fifo_push     = 1'b1;
            fifo_din.kind = CTM_EV_OVERFLOW;
            fifo_din.ts   = ts_q;
            fifo_din.pc   = ADDR_WIDTH'(ovf_rec);
            fifo_din.npc  = '0;
            ovf_cnt_d     = '0;
        end else if (qual && !fifo_full) begin
            fifo_push     = 1'b1;
            fifo_din.kind = kind_sel;
            fifo_din.ts   = ts_q;
            fifo_din.pc   = trace_pc;
            fifo_din.npc  = trace_npc;
        end else if (qual) begin
            ovf_cnt_d     = ovf_sat;
        end
    end

    peripheral_dbg_soc_ctm_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (ev_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .level (level)
    );

    // Head of queue drives the consumer interface
    always_comb begin
        ev_valid = ~fifo_empty;
        ev_kind  = fifo_dout.kind;
        ev_ts    = fifo_dout.ts;
        ev_pc    = fifo_dout.pc;
        ev_npc   = fifo_dout.npc;
    end

endmodule

// File: tb/tb_peripheral_dbg_soc_ctm_trace_capture.sv
// Directed bench: default instance plus a small instance (DEPTH 2, TS 8, OVF 4)
// sharing the same stimulus.
module tb_peripheral_dbg_soc_ctm_trace_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_npc;
    logic        trace_jal;
    logic        trace_jalr;
    logic        trace_branch;
    logic        trace_br_taken;
    logic        ev_ready;

    logic        ev_valid;
    logic [1:0]  ev_kind;
    logic [31:0] ev_ts;
    logic [31:0] ev_pc;
    logic [31:0] ev_npc;
    logic [3:0]  level;

    logic        s_ev_valid;
    logic [1:0]  s_ev_kind;
    logic [7:0]  s_ev_ts;
    logic [31:0] s_ev_pc;
    logic [31:0] s_ev_npc;
    logic [1:0]  s_level;

    int unsigned edges;
    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] ts_a;
    logic [31:0] ts_b;

    always #5 clk = ~clk;

    peripheral_dbg_soc_ctm_trace_capture u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_npc      (trace_npc),
        .trace_jal      (trace_jal),
        .trace_jalr     (trace_jalr),
        .trace_branch   (trace_branch),
        .trace_br_taken (trace_br_taken),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_kind        (ev_kind),
        .ev_ts          (ev_ts),
        .ev_pc          (ev_pc),
        .ev_npc         (ev_npc),
        .level          (level)
    );

    peripheral_dbg_soc_ctm_trace_capture #(
        .ADDR_WIDTH (32),
        .TS_WIDTH   (8),
        .FIFO_DEPTH (2),
        .OVF_WIDTH  (4)
    ) u_small (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_npc      (trace_npc),
        .trace_jal      (trace_jal),
        .trace_jalr     (trace_jalr),
        .trace_branch   (trace_branch),
        .trace_br_taken (trace_br_taken),
        .ev_valid       (s_ev_valid),
        .ev_ready       (ev_ready),
        .ev_kind        (s_ev_kind),
        .ev_ts          (s_ev_ts),
        .ev_pc          (s_ev_pc),
        .ev_npc         (s_ev_npc),
        .level          (s_level)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        if (!rst) edges++;
        #1;
    endtask

    task automatic idle();
        trace_valid    = 1'b0;
        trace_jal      = 1'b0;
        trace_jalr     = 1'b0;
        trace_branch   = 1'b0;
        trace_br_taken = 1'b0;
        trace_pc       = '0;
        trace_npc      = '0;
    endtask

    task automatic inj(input logic j, input logic jr, input logic br, input logic tk,
                       input logic [31:0] pc, input logic [31:0] npc);
        trace_valid    = 1'b1;
        trace_jal      = j;
        trace_jalr     = jr;
        trace_branch   = br;
        trace_br_taken = tk;
        trace_pc       = pc;
        trace_npc      = npc;
    endtask

    task automatic drain(input string tag);
        idle();
        ev_ready = 1'b1;
        repeat (24) step();
        ev_ready = 1'b0;
        check_eq({tag, "_level"}, 64'(level), 64'd0);
        check_eq({tag, "_s_level"}, 64'(s_level), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        ev_ready = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        edges = 0;

        // Reset state
        check_eq("rst_valid", 64'(ev_valid), 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_kind", 64'(ev_kind), 64'd0);
        check_eq("rst_pc", 64'(ev_pc), 64'd0);
        check_eq("rst_ts", 64'(ev_ts), 64'd0);
        check_eq("rst_s_level", 64'(s_level), 64'd0);

        // Single JAL at ts=5
        repeat (5) step();
        inj(1, 0, 0, 0, 32'h100, 32'h200);
        step();
        idle();
        check_eq("jal_valid", 64'(ev_valid), 64'd1);
        check_eq("jal_kind", 64'(ev_kind), 64'd0);
        check_eq("jal_pc", 64'(ev_pc), 64'h100);
        check_eq("jal_npc", 64'(ev_npc), 64'h200);
        check_eq("jal_ts", 64'(ev_ts), 64'd5);
        check_eq("jal_level", 64'(level), 64'd1);
        check_eq("jal_s_ts", 64'(s_ev_ts), 64'd5);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check_eq("jal_popped", 64'(ev_valid), 64'd0);

        // Filtering: untaken branch, ALU op, JAL+JALR
        inj(0, 0, 1, 0, 32'h280, 32'h290);
        step();
        inj(0, 0, 0, 0, 32'h284, 32'h0);
        step();
        inj(1, 1, 0, 0, 32'h300, 32'h400);
        step();
        idle();
        check_eq("filt_level", 64'(level), 64'd1);
        check_eq("filt_kind", 64'(ev_kind), 64'd1);
        check_eq("filt_pc", 64'(ev_pc), 64'h300);
        drain("filt");

        // Taken branch kind
        inj(0, 0, 1, 1, 32'h500, 32'h540);
        step();
        idle();
        check_eq("br_kind", 64'(ev_kind), 64'd2);
        check_eq("br_npc", 64'(ev_npc), 64'h540);
        drain("br");

        // Overflow: 11 JALs into 8 entries
        for (int i = 0; i < 11; i++) begin
            inj(1, 0, 0, 0, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(i));
            step();
        end
        idle();
        check_eq("ovf_level", 64'(level), 64'd8);
        check_eq("ovf_s_level", 64'(s_level), 64'd2);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_pop_pc", 64'(ev_pc), 64'(32'h1000 + 32'(4 * i)));
            step();
        end
        check_eq("ovf_rec_kind", 64'(ev_kind), 64'd3);
        check_eq("ovf_rec_pc", 64'(ev_pc), 64'd3);
        check_eq("ovf_rec_npc", 64'(ev_npc), 64'd0);
        inj(1, 0, 0, 0, 32'h5000, 32'h6000);
        step();
        idle();
        ev_ready = 1'b0;
        check_eq("ovf_next_kind", 64'(ev_kind), 64'd0);
        check_eq("ovf_next_pc", 64'(ev_pc), 64'h5000);
        check_eq("ovf_next_level", 64'(level), 64'd1);
        drain("ovf");

        // Full with same-cycle pop and event
        for (int i = 0; i < 8; i++) begin
            inj(1, 0, 0, 0, 32'h10 + 32'(i), 32'h0);
            step();
        end
        inj(1, 0, 0, 0, 32'h99, 32'h0);
        ev_ready = 1'b1;
        step();
        idle();
        ev_ready = 1'b0;
        check_eq("fp_level7", 64'(level), 64'd7);
        step();
        check_eq("fp_level8", 64'(level), 64'd8);
        ev_ready = 1'b1;
        repeat (7) step();
        check_eq("fp_rec_kind", 64'(ev_kind), 64'd3);
        check_eq("fp_rec_pc", 64'(ev_pc), 64'd1);
        drain("fp");

        // Saturation: 20 JALs; small instance saturates at 15
        for (int i = 0; i < 20; i++) begin
            inj(1, 0, 0, 0, 32'h7000 + 32'(i), 32'h0);
            step();
        end
        idle();
        ev_ready = 1'b1;
        repeat (2) step();
        check_eq("sat_s_kind", 64'(s_ev_kind), 64'd3);
        check_eq("sat_s_pc", 64'(s_ev_pc), 64'd15);
        repeat (6) step();
        check_eq("sat_kind", 64'(ev_kind), 64'd3);
        check_eq("sat_pc", 64'(ev_pc), 64'd12);
        drain("sat");

        // enable=0: no captures, pending record still emitted
        for (int i = 0; i < 9; i++) begin
            inj(1, 0, 0, 0, 32'h8000 + 32'(i), 32'h0);
            step();
        end
        enable = 1'b0;
        inj(1, 0, 0, 0, 32'h8800, 32'h0);
        ev_ready = 1'b1;
        repeat (8) step();
        check_eq("en_rec_kind", 64'(ev_kind), 64'd3);
        check_eq("en_rec_pc", 64'(ev_pc), 64'd1);
        step();
        check_eq("en_no_push", 64'(level), 64'd0);
        ev_ready = 1'b0;
        repeat (3) step();
        check_eq("en_off_level", 64'(level), 64'd0);
        check_eq("en_off_valid", 64'(ev_valid), 64'd0);
        enable = 1'b1;
        drain("en");

        // Timestamp wrap in the 8-bit instance
        while ((edges % 256) != 255) step();
        ts_a = 32'(edges);
        inj(1, 0, 0, 0, 32'hA, 32'h0);
        step();
        ts_b = 32'(edges);
        inj(1, 0, 0, 0, 32'hB, 32'h0);
        step();
        idle();
        check_eq("wrap_s_ts0", 64'(s_ev_ts), 64'hFF);
        check_eq("wrap_ts0", 64'(ev_ts), 64'(ts_a));
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check_eq("wrap_s_ts1", 64'(s_ev_ts), 64'h00);
        check_eq("wrap_ts1", 64'(ev_ts), 64'(ts_b));
        drain("wrap");

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) begin
            inj(1, 0, 0, 0, 32'h9000 + 32'(i), 32'h0);
            step();
        end
        idle();
        ev_ready = 1'b1;
        step();
        check_eq("rd_level3", 64'(level), 64'd3);
        #2;
        rst      = 1'b1;
        ev_ready = 1'b0;
        #1;
        check_eq("rd_valid", 64'(ev_valid), 64'd0);
        check_eq("rd_level", 64'(level), 64'd0);
        check_eq("rd_s_valid", 64'(s_ev_valid), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        edges = 0;
        repeat (2) step();
        inj(1, 0, 0, 0, 32'hC0, 32'hD0);
        step();
        idle();
        check_eq("rd_post_ts", 64'(ev_ts), 64'd2);
        check_eq("rd_post_pc", 64'(ev_pc), 64'hC0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
